demux_rr_scheduler: RTL and testbench
=====================================

Name: demux_rr_scheduler

Overview:
- Sequencer for a 1-to-4 demultiplexer datapath: takes bursts from a single valid/ready source and steers each whole burst to one of four destinations.
- Picks the destination round-robin among enabled destinations.
- Drives the demux `selector` and gates per-destination valid/ready.
- Sits between a shared producer and four consumer lanes; owns all sharing decisions for the demux.

Parameters:
- DATA_W, 8, width of the data beat.
- LEN_W, 4, width of the burst length field; burst length = burst_len+1, range 1..2^LEN_W beats.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  source beat valid.
- in_data  input  DATA_W  source beat data.
- in_ready  output  1  source beat accepted when in_valid & in_ready.
- burst_len  input  LEN_W  beats-1 of the next burst; sampled at grant.
- dest_en  input  4  per-destination enable for arbitration.
- out_valid  output  4  per-destination valid; at most one bit set.
- out_data  output  DATA_W  shared data to all destinations.
- out_ready  input  4  per-destination ready.
- selector  output  2  index of the granted destination, to the demux.
- busy  output  1  high while in XFER.
- burst_done  output  1  one-cycle pulse after the last beat of a burst.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, selector=0, last_grant=3 (so the first grant goes to dest 0), beat counter=0.
  - in_ready=0, out_valid=0, busy=0, burst_done=0.
  - Reset mid-burst aborts the burst; the partial burst is not resumed.
- States: IDLE, XFER, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - If in_valid=1 and dest_en!=0: grant the first enabled index searching last_grant+1, +2, +3, +4 (mod 4).
  - On grant: register selector=grant, last_grant=grant, len_q=burst_len, cnt=0; next state XFER.
  - If dest_en=0 or in_valid=0: stay in IDLE with no grant.
  - Arbitration costs exactly one cycle; the earliest first beat is the cycle after in_valid is seen in IDLE.
- XFER:
  - busy=1.
  - out_valid[selector]=in_valid; other out_valid bits 0.
  - in_ready=out_ready[selector]; out_ready of non-granted destinations is ignored.
  - out_data=in_data, combinational pass-through, zero latency.
  - A beat transfers when in_valid & out_ready[selector]; cnt increments on each beat.
  - A beat with cnt==len_q is the last beat; next state DONE.
  - Stalls from either side hold cnt; there is no timeout.
  - dest_en and burst_len changes during XFER are ignored; the burst always completes to the granted destination.
- DONE:
  - burst_done=1, in_ready=0, out_valid=0, busy=0 for exactly one cycle; next state IDLE.
  - Minimum gap between bursts is 2 cycles (DONE + IDLE arbitration).
- Outputs are registered (state, selector, burst_done) or combinational from registered state plus handshake inputs only; there is no combinational path from dest_en to out_valid.
- Wrap-around:
  - cnt is LEN_W bits; with burst_len all-ones the burst is 2^LEN_W beats and cnt never overflows before the last beat.
  - last_grant wraps 3→0.
- Simultaneous events:
  - in_valid dropping in the IDLE grant cycle still completes the grant; XFER then waits for in_valid.
  - Last beat and a new in_valid in the same cycle: the new burst is arbitrated only after DONE.

Test Plan:
- Reset, then dest_en=4'b1111, burst_len=0, four single-beat bursts with data 0x11,0x22,0x33,0x44, all out_ready=1 → grants in order selector=0,1,2,3; one out_valid per burst; burst_done pulses 4 times, each 1 cycle after its beat.
- dest_en=4'b1010, three bursts of burst_len=2 (3 beats each) → grants 1,3,1; each destination sees exactly 3 beats; non-enabled out_valid bits never set.
- Grant to dest 2 with burst_len=3; hold out_ready[2]=0 for 5 cycles mid-burst while out_ready[0,1,3]=1 → in_ready=0 during the stall, data held, no beat lost or duplicated; 4 beats total delivered to dest 2.
- dest_en=0 with in_valid=1 for 10 cycles → stays IDLE, in_ready=0, busy=0; set dest_en=4'b0100 → selector=2 next cycle, transfer starts the cycle after.
- Burst with burst_len=4'hF → exactly 16 beats to the granted destination, then burst_done; toggling dest_en and burst_len mid-burst has no effect.
- Assert rst_n=0 on beat 2 of a 4-beat burst → all outputs 0 immediately (async); after release the next grant is dest 0 regardless of the prior last_grant.

Source files
------------

// File: rtl/demux_rr_scheduler.sv
// ----------------------------------------------------------------------------
// demux_rr_scheduler
//   Sequencer for a 1-to-4 demux datapath. Whole bursts from one valid/ready
//   source are steered to one destination, chosen round-robin among the
//   enabled destinations. One arbitration cycle (IDLE), the burst itself
//   (XFER), then a single burst_done cycle (DONE).
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_data      source beat
//   in_ready              source beat accepted when in_valid & in_ready
//   burst_len             beats-1 of the next burst, sampled at grant
//   dest_en               per-destination arbitration enable
//   out_valid/out_data    per-destination valid (one-hot or zero), shared data
//   out_ready             per-destination ready
//   selector              granted destination index, to the demux
//   busy                  high while in XFER
//   burst_done            one-cycle pulse after the last beat of a burst
// ----------------------------------------------------------------------------

// Per-destination handshake gating: a lane only sees valid, and only
// contributes ready, while it is the granted lane of an active burst.
module demux_rr_lane (
  input  logic hit_i,
  input  logic xfer_i,
  input  logic in_valid_i,
  input  logic out_ready_i,
  output logic valid_o,
  output logic ready_o
);
  assign valid_o = xfer_i & hit_i & in_valid_i;
  assign ready_o = xfer_i & hit_i & out_ready_i;
endmodule

module demux_rr_scheduler #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [3:0]        dest_en,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
  output logic [1:0]        selector,
  output logic              busy,
  output logic              burst_done
);
  localparam int NUM_DEST = 4;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q;
  logic [1:0]        sel_q;
  logic [1:0]        last_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              done_q;

  logic              xfer;
  logic              beat;
  logic              grant_vld;
  logic [1:0]        grant_idx;
  logic [NUM_DEST-1:0] lane_vld;
  logic [NUM_DEST-1:0] lane_rdy;

  // Round-robin search last+1 .. last+4 (mod 4). Walking k downwards lets
  // the smallest offset win, i.e. the nearest enabled index after last_q.
  always_comb begin
    grant_vld = |dest_en;
    grant_idx = last_q;
    for (int k = NUM_DEST; k >= 1; k--) begin
      if (dest_en[2'(last_q + 2'(k))]) grant_idx = 2'(last_q + 2'(k));
    end
  end

  assign xfer = (state_q == XFER);

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_lane
    demux_rr_lane u_lane (
      .hit_i       (sel_q == 2'(i)),
      .xfer_i      (xfer),
      .in_valid_i  (in_valid),
      .out_ready_i (out_ready[i]),
      .valid_o     (lane_vld[i]),
      .ready_o     (lane_rdy[i])
    );
  end

  assign out_valid  = lane_vld;
  assign in_ready   = |lane_rdy;
  assign out_data   = in_data;
  assign beat       = in_valid & in_ready;
  assign selector   = sel_q;
  assign busy       = xfer;
  assign burst_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= 2'd3;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // Grant is taken on this cycle's in_valid; if the source drops
          // valid afterwards XFER simply waits for it.
          if (in_valid && grant_vld) begin
            state_q <= XFER;
            sel_q   <= grant_idx;
            last_q  <= grant_idx;
            len_q   <= burst_len;
            cnt_q   <= '0;
          end
        end
        XFER: begin
          if (beat) begin
            // Last beat leaves cnt at len_q, so an all-ones length never
            // wraps the counter mid-burst.
            if (cnt_q == len_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_demux_rr_scheduler
//   Directed bench for demux_rr_scheduler. Inputs change 1 time unit after
//   the rising edge; outputs are checked 1 unit later, well away from the edge.
// ----------------------------------------------------------------------------
module tb_demux_rr_scheduler;
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] burst_len;
  logic [3:0] dest_en;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [3:0] out_ready;
  logic [1:0] selector;
  logic       busy;
  logic       burst_done;

  int n_vec;
  int n_err;

  demux_rr_scheduler #(.DATA_W(8), .LEN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .burst_len  (burst_len),
    .dest_en    (dest_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .selector   (selector),
    .busy       (busy),
    .burst_done (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE at edge+1 with all out_ready high. Runs one burst of
  // nbeats with data d0, d0+1, ... and checks grant, every beat, and the
  // burst_done cycle. With toggle set, dest_en/burst_len change mid-burst.
  task automatic run_burst(input logic [1:0] exp_sel, input int nbeats,
                           input logic [7:0] d0, input bit toggle);
    logic [3:0] oh;
    oh = 4'b0001 << exp_sel;
    in_valid = 1'b1;
    in_data  = d0;
    #1;
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    tick();
    chk("grant_sel", selector, exp_sel);
    chk("xfer_busy", busy, 1);
    for (int b = 0; b < nbeats; b++) begin
      in_data = d0 + 8'(b);
      if (toggle && b == 5) begin
        dest_en   = 4'b0001;
        burst_len = 4'h0;
      end
      #1;
      chk("beat_valid", out_valid, oh);
      chk("beat_data", out_data, d0 + 8'(b));
      chk("beat_ready", in_ready, 1);
      chk("beat_done_low", burst_done, 0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("done_pulse", burst_done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", out_valid, 0);
    chk("done_ready", in_ready, 0);
    tick();
    chk("idle_done_low", burst_done, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    burst_len = 4'h0;
    dest_en = 4'h0;
    out_ready = 4'hF;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_sel", selector, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Four single-beat bursts, all enabled: grants 0,1,2,3.
    dest_en = 4'hF;
    burst_len = 4'h0;
    run_burst(2'd0, 1, 8'h11, 1'b0);
    run_burst(2'd1, 1, 8'h22, 1'b0);
    run_burst(2'd2, 1, 8'h33, 1'b0);
    run_burst(2'd3, 1, 8'h44, 1'b0);

    // Only 1 and 3 enabled, 3-beat bursts: grants 1,3,1.
    dest_en = 4'b1010;
    burst_len = 4'h2;
    run_burst(2'd1, 3, 8'h50, 1'b0);
    run_burst(2'd3, 3, 8'h60, 1'b0);
    run_burst(2'd1, 3, 8'h70, 1'b0);

    // Stall on dest 2 for 5 cycles in the middle of a 4-beat burst.
    dest_en = 4'hF;
    burst_len = 4'h3;
    in_valid = 1'b1;
    in_data = 8'h30;
    tick();
    chk("stall_sel", selector, 2);
    for (int b = 0; b < 2; b++) begin
      in_data = 8'h30 + 8'(b);
      #1;
      chk("stall_pre_ready", in_ready, 1);
      tick();
    end
    out_ready = 4'b1011;
    in_data = 8'h32;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 4'b0100);
      chk("stall_data", out_data, 8'h32);
      chk("stall_busy", busy, 1);
      tick();
    end
    out_ready = 4'hF;
    for (int b = 2; b < 4; b++) begin
      in_data = 8'h30 + 8'(b);
      #1;
      chk("stall_post_ready", in_ready, 1);
      chk("stall_post_done", burst_done, 0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("stall_done", burst_done, 1);
    tick();

    // No destination enabled: stay IDLE while in_valid is held.
    dest_en = 4'h0;
    burst_len = 4'h0;
    in_valid = 1'b1;
    in_data = 8'h4A;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("noen_ready", in_ready, 0);
      chk("noen_busy", busy, 0);
      tick();
    end
    dest_en = 4'b0100;
    tick();
    chk("en2_sel", selector, 2);
    chk("en2_busy", busy, 1);
    chk("en2_valid", out_valid, 4'b0100);
    chk("en2_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("en2_done", burst_done, 1);
    tick();

    // 16-beat burst, length/enable changes mid-burst ignored. last=2 -> 3.
    dest_en = 4'hF;
    burst_len = 4'hF;
    run_burst(2'd3, 16, 8'h80, 1'b1);

    // Reset on beat 2 of a 4-beat burst to dest 0.
    dest_en = 4'hF;
    burst_len = 4'h3;
    in_valid = 1'b1;
    in_data = 8'hA0;
    tick();
    chk("rb_sel", selector, 0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rb_valid", out_valid, 0);
    chk("rb_ready", in_ready, 0);
    chk("rb_busy", busy, 0);
    chk("rb_sel_rst", selector, 0);
    tick();
    rst_n = 1'b1;
    burst_len = 4'h0;
    run_burst(2'd0, 1, 8'hB0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
